// File: rtl/bs_rr_arbiter_router.sv
// Round-robin arbiter/router: grants one device FIFO, pops its head packet and
// routes it by header to one device or broadcasts it, honouring receive-side full.
module bs_rr_arbiter_router #(
  parameter int drvrs = 4,
  parameter int pckg_sz = 16,
  parameter int ID_W = 8,
  parameter logic [ID_W-1:0] BCAST = {ID_W{1'b1}},
  localparam int GW = (drvrs > 1) ? $clog2(drvrs) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [drvrs-1:0]                  pndng,
  input  logic [drvrs-1:0][pckg_sz-1:0]     D_pop,
  input  logic [drvrs-1:0]                  full,
  output logic [drvrs-1:0]                  pop,
  output logic [drvrs-1:0]                  push,
  output logic [drvrs-1:0][pckg_sz-1:0]     D_push,
  output logic                              busy,
  output logic [GW-1:0]                     grant_id,
  output logic [15:0]                       drop_cnt
);

  typedef enum logic [1:0] {IDLE, POP, ROUTE, DROP} state_t;

  state_t             state;
  logic [GW-1:0]      last;
  logic [GW-1:0]      pick;
  logic [pckg_sz-1:0] pkt;
  logic [pckg_sz-1:0] head;
  logic [ID_W-1:0]    dst;
  logic [drvrs-1:0]   targets;
  logic [drvrs-1:0]   one;

  assign one  = drvrs'(1);
  assign head = D_pop[grant_id];
  assign dst  = head[pckg_sz-1 -: ID_W];

  // Scan from the farthest candidate down to last+1 so the nearest requester wins.
  always_comb begin
    int idx;
    idx  = 0;
    pick = last;
    for (int k = drvrs; k >= 1; k--) begin
      idx = (int'(last) + k) % drvrs;
      if (pndng[idx[GW-1:0]]) pick = idx[GW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      last     <= GW'(drvrs - 1);
      grant_id <= '0;
      pop      <= '0;
      push     <= '0;
      D_push   <= '0;
      busy     <= 1'b0;
      drop_cnt <= '0;
      pkt      <= '0;
      targets  <= '0;
    end else begin
      pop  <= '0;
      push <= '0;
      case (state)
        IDLE: begin
          if (|pndng) begin
            grant_id <= pick;
            last     <= pick;
            pop      <= one << pick;
            busy     <= 1'b1;
            state    <= POP;
          end
        end
        POP: begin
          pkt <= head;
          if (dst == BCAST) begin
            targets <= ~(one << grant_id);
            state   <= ROUTE;
          end else if (int'(dst) < drvrs && int'(dst) != int'(grant_id)) begin
            targets <= one << dst;
            state   <= ROUTE;
          end else begin
            state <= DROP;
          end
        end
        ROUTE: begin
          // Broadcast is all-or-nothing: any full target stalls every lane.
          if ((targets & full) == '0) begin
            push   <= targets;
            D_push <= {drvrs{pkt}};
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        DROP: begin
          if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bs_rr_arbiter_router.md
Name: bs_rr_arbiter_router

Overview:
- Parametrised successor of the shared-bus generator/arbiter: one central block that arbitrates among `drvrs` device FIFOs, pops one packet and routes it to the device addressed in its header.
- Over the previous generation it adds:
  - round-robin fairness;
  - broadcast;
  - per-destination backpressure through `full`;
  - dropping of invalid packets, with a saturating drop counter.
- Sits between the per-device driver FIFOs and the device receive FIFOs in the bus testbench environment.

Parameters:
- drvrs, 4, number of attached devices (2..16).
- pckg_sz, 16, packet width in bits (must be > ID_W).
- ID_W, 8, header width; destination ID = D_pop[g][pckg_sz-1 -: ID_W].
- BCAST, {ID_W{1'b1}}, broadcast destination ID.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- pndng  in  [drvrs-1:0]  device i has a packet waiting; D_pop[i] is valid while high (first-word fall-through).
- D_pop  in  [drvrs-1:0][pckg_sz-1:0]  head packet of each device FIFO.
- full  in  [drvrs-1:0]  receive FIFO of device i cannot accept a push.
- pop  out  [drvrs-1:0]  one-cycle pop strobe to the granted source.
- push  out  [drvrs-1:0]  one-cycle push strobe(s) to destination(s).
- D_push  out  [drvrs-1:0][pckg_sz-1:0]  routed packet; identical value on every lane.
- busy  out  1  high in every state except IDLE.
- grant_id  out  [$clog2(drvrs)-1:0]  index of the current/last granted source.
- drop_cnt  out  16  count of dropped packets, saturates at 16'hFFFF.

Behaviour:
- Reset (reset=1 at a clock edge) forces:
  - pop=0, push=0, D_push=0, busy=0, grant_id=0, drop_cnt=0;
  - state=IDLE;
  - rr pointer last=drvrs-1, so device 0 has first priority.
- Reset has priority over everything. Asserting it mid-operation discards the captured packet; no pop or push strobe appears in the following cycle.
- All outputs are registered.
- FSM states: IDLE, POP, ROUTE, DROP.
- IDLE:
  - If any pndng is set, grant g = first set bit searching from last+1 upward, wrapping modulo drvrs.
  - Register g into grant_id and last; next state is POP.
  - If no pndng is set, stay in IDLE.
- POP:
  - pop[g]=1 for exactly this one cycle, and D_pop[g] is captured into pkt.
  - Decode dst = pkt header:
    - dst==BCAST → ROUTE, with targets = all devices except g.
    - dst<drvrs and dst!=g → ROUTE, with targets = one-hot(dst).
    - otherwise (out of range, or self-addressed) → DROP.
- ROUTE:
  - Wait while (targets & full) != 0; pop and push stay 0 during the wait.
  - When no target is full: push=targets for one cycle, D_push lanes=pkt, next state IDLE.
  - A broadcast is all-or-nothing: pushes to all targets happen in the same cycle.
  - full is sampled every cycle and there is no timeout.
- DROP: drop_cnt increments by 1 unless it is already 16'hFFFF; one cycle; next state IDLE.
- Latency (pndng first seen at edge t):
  - pop high during cycle t+1;
  - push high during cycle t+2 at the earliest;
  - next grant decided at edge t+3, so one packet per 3 cycles at best.
- D_push holds its last value when push=0.
- grant_id persists after the transfer.
- pndng changes while busy are ignored until return to IDLE.
- Fairness: with all pndng held high, grants cycle 0,1,…,drvrs-1,0… with no repeats.
- A single requester is re-granted back-to-back; the wrap from drvrs-1 to 0 is correct.

Test Plan:
- Reset then single unicast: pndng[1]=1, D_pop[1]=16'h02AB → pop[1] one cycle, then push=4'b0100 with D_push=16'h02AB, busy returns to 0, drop_cnt=0.
- Round robin: pndng=4'b1111 held, all packets valid → grant_id sequence 0,1,2,3,0; exactly one pop per grant; each source served once per 4 transfers.
- Broadcast with backpressure: pndng[2]=1, D_pop[2]=16'hFF55, full=4'b0001 for 5 cycles → push stays 0 for those 5 cycles, then a single cycle with push=4'b1011, all lanes 16'hFF55.
- Drops: D_pop[0] headers 8'h07 (out of range) and 8'h00 (self-addressed) → no push, drop_cnt=2; force 65537 drops → drop_cnt=16'hFFFF.
- Reset mid-operation: assert reset during ROUTE while full holds the destination blocked → next cycle push=0, pop=0, busy=0, drop_cnt=0; after release, device 0 is granted first.
- Parameter sweep: drvrs=8, pckg_sz=32, unicast 0→7 and 7→0, plus a broadcast from 5 → correct one-hot push; broadcast push=8'hDF.
